video_pixel_fifo: RTL and testbench

- Parametrised successor to the single-shot load/shift pixel buffer in the VGA path.
- A circular pixel FIFO that sits between the frame-memory reader and the VGA timing generator.
- Accepts multi-pixel load words, emits one pixel per `need_pixel` request, and reports level, low-watermark and underrun status.
- Adds a priming state, so output starts only once enough pixels are buffered.

---
 rtl/video_pixel_fifo.sv | 153 +++++++++++++++
 tb/tb_video_pixel_fifo.sv | 266 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/video_pixel_fifo.sv
// Circular pixel FIFO between the frame-memory reader and the VGA timing generator.
// Optional underrun counter enabled by defining VIDEO_PIXEL_FIFO_UNDERRUN_CNT_EN.
module video_pixel_fifo #(
  parameter int PIX_W     = 8,
  parameter int LOAD_PIX  = 2,
  parameter int DEPTH     = 16,
  parameter int LOW_WM    = 4,
  parameter int START_LVL = 8
) (
  input  logic                      clk25MHz,
  input  logic                      rst,
  input  logic                      en,
  input  logic                      flush,
  input  logic [LOAD_PIX*PIX_W-1:0] data,
  input  logic                      load,
  output logic                      load_ready,
  input  logic                      need_pixel,
  output logic [PIX_W-1:0]          video,
  output logic                      video_valid,
  output logic [$clog2(DEPTH):0]    level,
  output logic                      empty,
  output logic                      full,
  output logic                      low_watermark,
  output logic                      underflow,
  output logic [15:0]               underrun_count
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;

  localparam logic [LW-1:0] DEPTH_L    = LW'(DEPTH);
  localparam logic [LW-1:0] LOAD_L     = LW'(LOAD_PIX);
  localparam logic [LW-1:0] LOW_L      = LW'(LOW_WM);
  localparam logic [LW-1:0] START_L    = LW'(START_LVL);
  localparam logic [LW-1:0] LOAD_MAX_L = LW'(DEPTH - LOAD_PIX);
  localparam logic [AW-1:0] LOAD_STEP  = AW'(LOAD_PIX);

  typedef enum logic {
    PRIME,
    RUN
  } state_t;

  state_t state, state_next;

  logic [PIX_W-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             do_load;
  logic             do_pop;
  logic             do_underrun;

  assign load_ready    = (level <= LOAD_MAX_L);
  assign empty         = (level == '0);
  assign full          = (level == DEPTH_L);
  assign low_watermark = (level <= LOW_L);

  always_ff @(posedge clk25MHz or negedge rst) begin
    if (!rst) begin
      state <= PRIME;
    end else begin
      state <= state_next;
    end
  end

  // A request on an empty FIFO is never satisfied by a same-cycle load.
  always_comb begin
    state_next  = state;
    do_load     = 1'b0;
    do_pop      = 1'b0;
    do_underrun = 1'b0;
    if (en) begin
      if (flush) begin
        state_next = PRIME;
      end else begin
        do_load = load && load_ready;
        case (state)
          PRIME: begin
            if (level >= START_L) state_next = RUN;
          end
          RUN: begin
            if (need_pixel) begin
              if (level != '0) begin
                do_pop = 1'b1;
              end else begin
                do_underrun = 1'b1;
                state_next  = PRIME;
              end
            end
          end
          default: state_next = PRIME;
        endcase
      end
    end
  end

  always_ff @(posedge clk25MHz) begin
    if (do_load) begin
      for (int i = 0; i < LOAD_PIX; i++) begin
        mem[wr_ptr + AW'(i)] <= data[(LOAD_PIX-1-i)*PIX_W +: PIX_W];
      end
    end
  end

  always_ff @(posedge clk25MHz or negedge rst) begin
    if (!rst) begin
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      level       <= '0;
      video       <= '0;
      video_valid <= 1'b0;
      underflow   <= 1'b0;
    end else if (en) begin
      if (flush) begin
        wr_ptr      <= '0;
        rd_ptr      <= '0;
        level       <= '0;
        video       <= '0;
        video_valid <= 1'b0;
        underflow   <= 1'b0;
      end else begin
        if (do_load) wr_ptr <= wr_ptr + LOAD_STEP;
        if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
        level     <= level + (do_load ? LOAD_L : '0) - (do_pop ? LW'(1) : '0);
        underflow <= do_underrun;
        // Unserved requests (PRIME or underrun) blank the pixel; no request keeps it.
        if (do_pop) begin
          video       <= mem[rd_ptr];
          video_valid <= 1'b1;
        end else begin
          video_valid <= 1'b0;
          if (need_pixel) video <= '0;
        end
      end
    end
  end

`ifdef VIDEO_PIXEL_FIFO_UNDERRUN_CNT_EN
  logic [15:0] underrun_cnt;

  always_ff @(posedge clk25MHz or negedge rst) begin
    if (!rst) begin
      underrun_cnt <= '0;
    end else if (do_underrun && (underrun_cnt != 16'hFFFF)) begin
      underrun_cnt <= underrun_cnt + 16'd1;
    end
  end

  assign underrun_count = underrun_cnt;
`else
  assign underrun_count = '0;
`endif

endmodule

// File: tb/tb_video_pixel_fifo.sv
// Scenario testbench for video_pixel_fifo with a queue-based pixel scoreboard.
module tb_video_pixel_fifo;

  localparam int PIX_W     = 8;
  localparam int LOAD_PIX  = 2;
  localparam int DEPTH     = 16;
  localparam int LOW_WM    = 4;
  localparam int START_LVL = 8;

  logic        clk25MHz = 1'b0;
  logic        rst;
  logic        en;
  logic        flush;
  logic [15:0] data;
  logic        load;
  logic        load_ready;
  logic        need_pixel;
  logic [7:0]  video;
  logic        video_valid;
  logic [4:0]  level;
  logic        empty;
  logic        full;
  logic        low_watermark;
  logic        underflow;
  logic [15:0] underrun_count;

  int total = 0;
  int bad   = 0;

  logic [7:0] exp_q [$];
  int         level_m;
  bit         prime_m;
  bit         exp_valid;
  logic [7:0] exp_video;
  bit         exp_uf;
  int         exp_urc;

  always #20 clk25MHz = ~clk25MHz;

  video_pixel_fifo #(
    .PIX_W(PIX_W), .LOAD_PIX(LOAD_PIX), .DEPTH(DEPTH),
    .LOW_WM(LOW_WM), .START_LVL(START_LVL)
  ) dut (
    .clk25MHz(clk25MHz), .rst(rst), .en(en), .flush(flush), .data(data),
    .load(load), .load_ready(load_ready), .need_pixel(need_pixel),
    .video(video), .video_valid(video_valid), .level(level), .empty(empty),
    .full(full), .low_watermark(low_watermark), .underflow(underflow),
    .underrun_count(underrun_count)
  );

  // Advance the reference model for the inputs currently driven, then clock once.
  task automatic tick();
    bit ld, pop, uf;
    if (en) begin
      if (flush) begin
        exp_q.delete();
        level_m   = 0;
        prime_m   = 1'b1;
        exp_valid = 1'b0;
        exp_video = 8'h00;
        exp_uf    = 1'b0;
      end else begin
        ld  = load && (level_m <= DEPTH - LOAD_PIX);
        pop = !prime_m && need_pixel && (level_m > 0);
        uf  = !prime_m && need_pixel && (level_m == 0);
        exp_valid = pop;
        if (pop) exp_video = exp_q.pop_front();
        else if (need_pixel) exp_video = 8'h00;
        if (ld) begin
          exp_q.push_back(data[15:8]);
          exp_q.push_back(data[7:0]);
        end
        exp_uf = uf;
`ifdef VIDEO_PIXEL_FIFO_UNDERRUN_CNT_EN
        if (uf && exp_urc < 16'hFFFF) exp_urc++;
`endif
        if (prime_m) prime_m = !(level_m >= START_LVL);
        else if (uf) prime_m = 1'b1;
        level_m = level_m + (ld ? LOAD_PIX : 0) - (pop ? 1 : 0);
      end
    end
    @(posedge clk25MHz);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b0; en = 1'b1; flush = 1'b0; data = '0; load = 1'b0; need_pixel = 1'b0;
    exp_q.delete();
    level_m = 0; prime_m = 1'b1; exp_valid = 1'b0; exp_video = 8'h00; exp_uf = 1'b0; exp_urc = 0;
    #7;
    @(negedge clk25MHz);
    rst = 1'b1;
  endtask

  task automatic do_flush();
    flush = 1'b1; load = 1'b0; need_pixel = 1'b0;
    tick();
    flush = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    @(posedge clk25MHz);
    #3;
    rst = 1'b0;
    #2;
    total++; if (level !== 5'd0) begin bad++; $display("FAIL reset_level: got %0d want 0", level); end
    total++; if ({empty, full, load_ready, low_watermark} !== 4'b1011) begin
      bad++; $display("FAIL reset_status: got e/f/lr/lw=%b want 1011", {empty, full, load_ready, low_watermark}); end
    total++; if ({video_valid, underflow, video} !== 10'd0) begin
      bad++; $display("FAIL reset_video: got valid=%b uf=%b video=%h want 0/0/00", video_valid, underflow, video); end
    total++; if (underrun_count !== 16'd0) begin bad++; $display("FAIL reset_urc: got %0d want 0", underrun_count); end
    @(negedge clk25MHz);
    rst = 1'b1;
  endtask

  task automatic test_basic_stream();
    logic [15:0] words [4];
    words = '{16'hA1B2, 16'hC3D4, 16'hE5F6, 16'h0718};
    for (int i = 0; i < 4; i++) begin
      load = 1'b1; data = words[i];
      tick();
    end
    load = 1'b0;
    tick();
    total++; if (level !== 5'd8) begin bad++; $display("FAIL stream_level: got %0d want 8", level); end
    need_pixel = 1'b1;
    for (int i = 0; i < 8; i++) begin
      tick();
      total++; if (video_valid !== exp_valid || video !== exp_video) begin
        bad++; $display("FAIL stream_pix%0d: got valid=%b video=%h want valid=%b video=%h", i, video_valid, video, exp_valid, exp_video); end
    end
    need_pixel = 1'b0;
    total++; if (empty !== 1'b1) begin bad++; $display("FAIL stream_empty: got %b want 1", empty); end
  endtask

  task automatic test_prime_hold();
    logic [15:0] words [4];
    words = '{16'h1122, 16'h3344, 16'h5566, 16'h7788};
    do_flush();
    need_pixel = 1'b1;
    for (int i = 0; i < 4; i++) begin
      load = 1'b1; data = words[i];
      tick();
      total++; if (video_valid !== 1'b0 || underflow !== 1'b0) begin
        bad++; $display("FAIL prime_hold%0d: got valid=%b uf=%b want 0/0", i, video_valid, underflow); end
    end
    load = 1'b0;
    for (int i = 0; i < 2; i++) begin
      tick();
      total++; if (video_valid !== exp_valid || video !== exp_video || underflow !== exp_uf) begin
        bad++; $display("FAIL prime_start%0d: got valid=%b video=%h uf=%b want %b/%h/%b", i, video_valid, video, underflow, exp_valid, exp_video, exp_uf); end
    end
    total++; if (video !== 8'h11) begin bad++; $display("FAIL prime_first_pix: got %h want 11", video); end
    need_pixel = 1'b0;
  endtask

  task automatic test_full_drop();
    do_flush();
    for (int k = 0; k < 8; k++) begin
      load = 1'b1; data = {8'(8'h10 + 2*k), 8'(8'h11 + 2*k)};
      tick();
    end
    total++; if ({full, load_ready} !== 2'b10 || level !== 5'd16) begin
      bad++; $display("FAIL full_status: got full=%b lr=%b level=%0d want 1/0/16", full, load_ready, level); end
    data = 16'hFFFF;
    tick();
    total++; if (level !== 5'(level_m)) begin bad++; $display("FAIL full_drop_level: got %0d want %0d", level, level_m); end
    load = 1'b0; need_pixel = 1'b1;
    tick();
    total++; if (video_valid !== exp_valid || video !== exp_video) begin
      bad++; $display("FAIL full_head: got valid=%b video=%h want valid=%b video=%h", video_valid, video, exp_valid, exp_video); end
    need_pixel = 1'b0;
  endtask

  task automatic test_underrun();
    need_pixel = 1'b1;
    for (int i = 0; i < 15; i++) begin
      tick();
      total++; if (video_valid !== exp_valid || video !== exp_video) begin
        bad++; $display("FAIL drain_pix%0d: got valid=%b video=%h want valid=%b video=%h", i, video_valid, video, exp_valid, exp_video); end
    end
    tick();
    total++; if (underflow !== 1'b1 || video_valid !== 1'b0 || video !== 8'h00) begin
      bad++; $display("FAIL underrun_pulse: got uf=%b valid=%b video=%h want 1/0/00", underflow, video_valid, video); end
    total++; if (underrun_count !== 16'(exp_urc)) begin
      bad++; $display("FAIL underrun_count: got %0d want %0d", underrun_count, exp_urc); end
    need_pixel = 1'b0;
    tick();
    total++; if (underflow !== 1'b0) begin bad++; $display("FAIL underrun_once: got %b want 0", underflow); end
    need_pixel = 1'b1;
    tick();
    total++; if (underflow !== 1'b0) begin bad++; $display("FAIL underrun_prime: got %b want 0", underflow); end
    need_pixel = 1'b0;
  endtask

  task automatic test_watermark();
    do_flush();
    for (int k = 0; k < 4; k++) begin
      load = 1'b1; data = {8'(8'h40 + 2*k), 8'(8'h41 + 2*k)};
      tick();
    end
    load = 1'b0;
    tick();
    need_pixel = 1'b1;
    for (int i = 0; i < 3; i++) tick();
    total++; if (level !== 5'd5 || low_watermark !== 1'b0) begin
      bad++; $display("FAIL wm_at5: got level=%0d lw=%b want 5/0", level, low_watermark); end
    load = 1'b1; data = 16'h5A5B;
    tick();
    total++; if (level !== 5'd6 || video !== exp_video) begin
      bad++; $display("FAIL wm_ldpop: got level=%0d video=%h want 6/%h", level, video, exp_video); end
    load = 1'b0;
    tick();
    tick();
    total++; if (level !== 5'd4 || low_watermark !== 1'b1) begin
      bad++; $display("FAIL wm_at4: got level=%0d lw=%b want 4/1", level, low_watermark); end
    load = 1'b1; data = 16'h6C6D;
    tick();
    total++; if (level !== 5'd5 || low_watermark !== 1'b0) begin
      bad++; $display("FAIL wm_rise5: got level=%0d lw=%b want 5/0", level, low_watermark); end
    load = 1'b0; need_pixel = 1'b0;
  endtask

  task automatic test_flush_enable();
    do_flush();
    for (int k = 0; k < 5; k++) begin
      load = 1'b1; data = {8'(8'h80 + k), 8'(8'h90 + k)};
      tick();
    end
    load = 1'b0;
    tick();
    total++; if (level !== 5'd10) begin bad++; $display("FAIL flush_pre_level: got %0d want 10", level); end
    flush = 1'b1; load = 1'b1; data = 16'hDEAD;
    tick();
    flush = 1'b0; load = 1'b0;
    total++; if (level !== 5'd0 || empty !== 1'b1) begin
      bad++; $display("FAIL flush_level: got level=%0d empty=%b want 0/1", level, empty); end
    need_pixel = 1'b1;
    tick();
    total++; if (underflow !== 1'b0 || video_valid !== 1'b0) begin
      bad++; $display("FAIL flush_prime: got uf=%b valid=%b want 0/0", underflow, video_valid); end
    need_pixel = 1'b0; load = 1'b1; data = 16'hBEEF;
    tick();
    en = 1'b0; need_pixel = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      total++; if (level !== 5'd2 || video_valid !== 1'b0 || underflow !== 1'b0) begin
        bad++; $display("FAIL enable_hold%0d: got level=%0d valid=%b uf=%b want 2/0/0", i, level, video_valid, underflow); end
    end
    en = 1'b1; load = 1'b0; need_pixel = 1'b0;
  endtask

  initial begin
    test_reset();
    test_basic_stream();
    test_prime_hold();
    test_full_drop();
    test_underrun();
    test_watermark();
    test_flush_enable();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
